// File: rtl/nn_inference_ctrl.sv
// nn_inference_ctrl: collects IN_SIZE signed feature samples into a register
// buffer that drives a combinational network. It waits SETTLE_CYCLES for the
// network to settle, captures the scores, and scans them one per cycle for the
// arg-max. The winning class is then held until the consumer accepts it.
// Optional feature: define NN_CTRL_THRESHOLD_EN to add the threshold input and
// the class_reject output, which flags a winning score below the threshold.
module nn_inference_ctrl #(
  parameter int IN_SIZE       = 13,
  parameter int OUT_SIZE      = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [7:0]           sample_in,
  input  logic                        sample_valid,
  output logic                        sample_ready,
  input  logic                        flush,
  output logic signed [7:0]           nn_input_vector [IN_SIZE],
  input  logic signed [15:0]          nn_probabilities [OUT_SIZE],
  output logic [$clog2(OUT_SIZE)-1:0] class_idx,
  output logic signed [15:0]          class_score,
  output logic                        class_valid,
  input  logic                        class_ready,
`ifdef NN_CTRL_THRESHOLD_EN
  input  logic signed [15:0]          threshold,
  output logic                        class_reject,
`endif
  output logic                        busy
);

  localparam int IDX_W = $clog2(IN_SIZE);
  localparam int CLS_W = $clog2(OUT_SIZE);
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {COLLECT, SETTLE, ARGMAX, RESULT} state_t;

  state_t                    state;
  logic [IDX_W-1:0]          idx;
  logic [CNT_W-1:0]          settle_cnt;
  logic [CLS_W-1:0]          aidx;
  logic signed [15:0]        scores [OUT_SIZE];

  logic signed [15:0]        cand_score;
  logic signed [15:0]        next_score;
  logic [CLS_W-1:0]          next_idx;
  logic                      take;

  // Strictly-greater signed compare, so ties keep the earlier (lower) index.
  function automatic logic score_beats(input logic signed [15:0] cand,
                                       input logic signed [15:0] best);
    return cand > best;
  endfunction

  // The scan step: the first score seeds the running maximum, and later
  // scores replace it only when strictly larger.
  always_comb begin
    cand_score = scores[aidx];
    take       = (aidx == '0) || score_beats(cand_score, class_score);
    next_score = take ? cand_score : class_score;
    next_idx   = take ? aidx : class_idx;
  end

  // Handshake and status flags depend only on the state register.
  assign sample_ready = (state == COLLECT);
  assign busy         = (state != COLLECT);

  // Controller FSM, sample buffer, score capture and the arg-max scan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= COLLECT;
      idx         <= '0;
      settle_cnt  <= '0;
      aidx        <= '0;
      class_idx   <= '0;
      class_score <= '0;
      class_valid <= 1'b0;
`ifdef NN_CTRL_THRESHOLD_EN
      class_reject <= 1'b0;
`endif
      for (int i = 0; i < IN_SIZE; i++) nn_input_vector[i] <= '0;
      for (int i = 0; i < OUT_SIZE; i++) scores[i] <= '0;
    end else if (flush) begin
      // Abort wins over any beat or result in the same cycle; the buffer
      // keeps its stale contents until new beats overwrite them.
      state       <= COLLECT;
      idx         <= '0;
      class_valid <= 1'b0;
`ifdef NN_CTRL_THRESHOLD_EN
      class_reject <= 1'b0;
`endif
    end else begin
      case (state)
        COLLECT: begin
          if (sample_valid) begin
            nn_input_vector[idx] <= sample_in;
            if (idx == IDX_W'(IN_SIZE - 1)) begin
              idx        <= '0;
              settle_cnt <= CNT_W'(SETTLE_CYCLES);
              state      <= SETTLE;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt - CNT_W'(1);
          if (settle_cnt == CNT_W'(1)) begin
            for (int i = 0; i < OUT_SIZE; i++) scores[i] <= nn_probabilities[i];
            aidx  <= '0;
            state <= ARGMAX;
          end
        end
        ARGMAX: begin
          class_idx   <= next_idx;
          class_score <= next_score;
          if (aidx == CLS_W'(OUT_SIZE - 1)) begin
            class_valid <= 1'b1;
`ifdef NN_CTRL_THRESHOLD_EN
            class_reject <= (next_score < threshold);
`endif
            state <= RESULT;
          end else begin
            aidx <= aidx + CLS_W'(1);
          end
        end
        RESULT: begin
          if (class_ready) begin
            class_valid <= 1'b0;
`ifdef NN_CTRL_THRESHOLD_EN
            class_reject <= 1'b0;
`endif
            idx   <= '0;
            state <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_inference_ctrl.sv
// Self-checking bench for nn_inference_ctrl. A small behavioural model (an
// expected buffer array and a plain arg-max loop) supplies every expected value.
module tb_nn_inference_ctrl;

  localparam int IN_SIZE  = 13;
  localparam int OUT_SIZE = 4;
  localparam int SETTLE   = 4;
  localparam int CLS_W    = $clog2(OUT_SIZE);

  logic                     clk = 1'b0;
  logic                     rst;
  logic signed [7:0]        sample_in;
  logic                     sample_valid;
  logic                     sample_ready;
  logic                     flush;
  logic signed [7:0]        nn_input_vector [IN_SIZE];
  logic signed [15:0]       nn_probabilities [OUT_SIZE];
  logic [CLS_W-1:0]         class_idx;
  logic signed [15:0]       class_score;
  logic                     class_valid;
  logic                     class_ready;
  logic                     busy;
`ifdef NN_CTRL_THRESHOLD_EN
  logic signed [15:0]       threshold;
  logic                     class_reject;
`endif

  // Reference model state.
  logic signed [7:0]        exp_buf [IN_SIZE];
  int                       exp_idx;
  int                       exp_w;
  logic signed [15:0]       exp_ws;
  logic signed [7:0]        samp [IN_SIZE];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nn_inference_ctrl #(.IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .flush(flush), .nn_input_vector(nn_input_vector),
    .nn_probabilities(nn_probabilities), .class_idx(class_idx), .class_score(class_score),
    .class_valid(class_valid), .class_ready(class_ready),
`ifdef NN_CTRL_THRESHOLD_EN
    .threshold(threshold), .class_reject(class_reject),
`endif
    .busy(busy)
  );

  task automatic model_clear();
    for (int i = 0; i < IN_SIZE; i++) exp_buf[i] = '0;
    exp_idx = 0;
  endtask

  // One accepted beat: drive at negedge, the model records it at the posedge.
  task automatic beat(input logic signed [7:0] v);
    @(negedge clk);
    n_tests++;
    if (sample_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL beat_ready: sample_ready=%b required 1 (slot %0d)", sample_ready, exp_idx);
    end
    sample_in = v;
    sample_valid = 1'b1;
    @(posedge clk);
    exp_buf[exp_idx % IN_SIZE] = v;
    exp_idx++;
    #1 sample_valid = 1'b0;
  endtask

  task automatic stream(input int gap_max);
    for (int i = 0; i < IN_SIZE; i++) begin
      if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) @(negedge clk);
      beat(samp[i]);
    end
  endtask

  task automatic rand_samples();
    for (int i = 0; i < IN_SIZE; i++) samp[i] = 8'($urandom);
  endtask

  // Called just after the posedge that accepted the final beat.
  task automatic wait_result(input string tag);
    int n;
    exp_w = 0;
    for (int i = 1; i < OUT_SIZE; i++)
      if (nn_probabilities[i] > nn_probabilities[exp_w]) exp_w = i;
    exp_ws = nn_probabilities[exp_w];
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!class_valid && n < 50);
    n_tests++;
    if (n != SETTLE + OUT_SIZE) begin
      n_fail++;
      $display("FAIL %s latency: class_valid after %0d edges, required %0d", tag, n, SETTLE + OUT_SIZE);
    end
    n_tests++;
    if (class_idx !== CLS_W'(exp_w)) begin
      n_fail++;
      $display("FAIL %s class_idx: got %0d required %0d", tag, class_idx, exp_w);
    end
    n_tests++;
    if (class_score !== exp_ws) begin
      n_fail++;
      $display("FAIL %s class_score: got %0d required %0d", tag, class_score, exp_ws);
    end
    n_tests++;
    if (busy !== 1'b1 || sample_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s result_flags: busy=%b sample_ready=%b required 1/0", tag, busy, sample_ready);
    end
    for (int i = 0; i < IN_SIZE; i++) begin
      n_tests++;
      if (nn_input_vector[i] !== exp_buf[i]) begin
        n_fail++;
        $display("FAIL %s buffer[%0d]: got %0d required %0d", tag, i, nn_input_vector[i], exp_buf[i]);
      end
    end
`ifdef NN_CTRL_THRESHOLD_EN
    n_tests++;
    if (class_reject !== (exp_ws < threshold)) begin
      n_fail++;
      $display("FAIL %s class_reject: got %b required %b", tag, class_reject, exp_ws < threshold);
    end
`endif
  endtask

  task automatic accept_result(input string tag);
    @(negedge clk);
    class_ready = 1'b1;
    @(posedge clk);
    #1 class_ready = 1'b0;
    exp_idx = 0;
    n_tests++;
    if (class_valid !== 1'b0 || sample_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s handshake: valid=%b ready=%b busy=%b required 0/1/0", tag, class_valid, sample_ready, busy);
    end
  endtask

  task automatic test_reset();
    #12;
    n_tests++;
    if (class_idx !== '0 || class_score !== '0 || class_valid !== 1'b0 || busy !== 1'b0 || sample_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_outputs: idx=%0d score=%0d valid=%b busy=%b ready=%b required 0/0/0/0/1",
               class_idx, class_score, class_valid, busy, sample_ready);
    end
    for (int i = 0; i < IN_SIZE; i++) begin
      n_tests++;
      if (nn_input_vector[i] !== 8'sd0) begin
        n_fail++;
        $display("FAIL reset_buffer[%0d]: got %0d required 0", i, nn_input_vector[i]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_basic();
    nn_probabilities = '{16'sd100, -16'sd5, 16'sd300, 16'sd20};
    for (int i = 0; i < IN_SIZE; i++) samp[i] = 8'(i + 1);
    stream(0);
    wait_result("basic");
    accept_result("basic");
  endtask

  task automatic test_ties();
    nn_probabilities = '{16'sd50, 16'sd50, 16'sd10, 16'sd0};
    rand_samples();
    stream(1);
    wait_result("tie");
    accept_result("tie");
    nn_probabilities = '{-16'sd10, -16'sd3, -16'sd7, -16'sd20};
    rand_samples();
    stream(0);
    wait_result("negatives");
    accept_result("negatives");
  endtask

  task automatic test_backpressure();
    nn_probabilities = '{16'sd7, 16'sd900, -16'sd900, 16'sd899};
    rand_samples();
    stream(0);
    wait_result("bp");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      sample_in = 8'($urandom);
      for (int k = 0; k < OUT_SIZE; k++) nn_probabilities[k] = 16'($urandom);
      @(posedge clk);
      #1;
      n_tests++;
      if (class_valid !== 1'b1 || class_idx !== CLS_W'(exp_w) || class_score !== exp_ws || sample_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d: valid=%b idx=%0d score=%0d ready=%b required 1/%0d/%0d/0",
                 c, class_valid, class_idx, class_score, sample_ready, exp_w, exp_ws);
      end
      for (int i = 0; i < IN_SIZE; i++) begin
        n_tests++;
        if (nn_input_vector[i] !== exp_buf[i]) begin
          n_fail++;
          $display("FAIL bp_buffer[%0d]: got %0d required %0d", i, nn_input_vector[i], exp_buf[i]);
        end
      end
    end
    sample_valid = 1'b0;
    accept_result("bp");
  endtask

  task automatic test_flush();
    for (int i = 0; i < 6; i++) beat(8'($urandom));
    @(negedge clk);
    sample_in = 8'sd7;
    sample_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    sample_valid = 1'b0;
    exp_idx = 0;
    n_tests++;
    if (nn_input_vector[6] !== exp_buf[6] || sample_ready !== 1'b1 || class_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_drop: buf6=%0d ready=%b valid=%b required %0d/1/0",
               nn_input_vector[6], sample_ready, class_valid, exp_buf[6]);
    end
    nn_probabilities = '{-16'sd1, 16'sd2, 16'sd3, 16'sd4};
    for (int i = 0; i < IN_SIZE; i++) samp[i] = 8'(21 + i);
    stream(0);
    wait_result("flush_refill");
    accept_result("flush_refill");
  endtask

  task automatic test_flush_busy();
    int seen;
    nn_probabilities = '{16'sd5, 16'sd6, 16'sd7, 16'sd8};
    rand_samples();
    stream(0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    exp_idx = 0;
    n_tests++;
    if (busy !== 1'b0 || sample_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_settle: busy=%b ready=%b required 0/1", busy, sample_ready);
    end
    seen = 0;
    repeat (15) begin
      @(posedge clk);
      #1 if (class_valid || busy) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL flush_settle_quiet: valid/busy high %0d cycles, required 0", seen);
    end
    rand_samples();
    stream(0);
    wait_result("flush_result_pre");
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    exp_idx = 0;
    n_tests++;
    if (class_valid !== 1'b0 || sample_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_result: valid=%b ready=%b required 0/1", class_valid, sample_ready);
    end
  endtask

  task automatic test_async_reset();
    nn_probabilities = '{16'sd500, 16'sd600, 16'sd100, 16'sd50};
    rand_samples();
    stream(0);
    repeat (6) @(posedge clk);
    #3;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre: busy=%b required 1", busy);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (class_idx !== '0 || class_score !== '0 || class_valid !== 1'b0 || busy !== 1'b0 || sample_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_outputs: idx=%0d score=%0d valid=%b busy=%b ready=%b required 0/0/0/0/1",
               class_idx, class_score, class_valid, busy, sample_ready);
    end
    for (int i = 0; i < IN_SIZE; i++) begin
      n_tests++;
      if (nn_input_vector[i] !== 8'sd0) begin
        n_fail++;
        $display("FAIL areset_buffer[%0d]: got %0d required 0", i, nn_input_vector[i]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    nn_probabilities = '{-16'sd4, 16'sd30, 16'sd31, -16'sd2};
    rand_samples();
    stream(0);
    wait_result("after_areset");
    accept_result("after_areset");
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < OUT_SIZE; k++) nn_probabilities[k] = 16'($urandom);
      if ($urandom_range(2, 0) == 0) nn_probabilities[$urandom_range(OUT_SIZE - 1, 1)] = nn_probabilities[0];
      rand_samples();
      stream(2);
      wait_result("random");
      repeat ($urandom_range(3, 0)) @(negedge clk);
      accept_result("random");
    end
  endtask

`ifdef NN_CTRL_THRESHOLD_EN
  task automatic test_threshold();
    threshold = 16'sd200;
    nn_probabilities = '{16'sd150, -16'sd1, 16'sd100, 16'sd0};
    rand_samples();
    stream(0);
    wait_result("thr_reject");
    accept_result("thr_reject");
    nn_probabilities = '{16'sd150, 16'sd300, 16'sd100, 16'sd0};
    rand_samples();
    stream(0);
    wait_result("thr_accept");
    accept_result("thr_accept");
  endtask
`endif

  initial begin
    rst = 1'b1;
    sample_in = '0;
    sample_valid = 1'b0;
    flush = 1'b0;
    class_ready = 1'b0;
    nn_probabilities = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
`ifdef NN_CTRL_THRESHOLD_EN
    threshold = 16'sd200;
`endif
    model_clear();
    test_reset();
    test_basic();
    test_ties();
    test_backpressure();
    test_flush();
    test_flush_busy();
    test_async_reset();
    test_random();
`ifdef NN_CTRL_THRESHOLD_EN
    test_threshold();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
